// File: rtl/stamp_pkg.sv
// Types and constants shared by the timestamp encoder and the spike dispatcher.
package stamp_pkg;

   localparam int STAMP_W    = 4;
   localparam int EVT_ADDR_W = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } disp_state_t;

   typedef struct packed {
      logic [STAMP_W-1:0]    stamp;
      logic [EVT_ADDR_W-1:0] addr;
   } spike_evt_t;

endpackage

// File: rtl/stamp_bank_fifo.sv
// Show-ahead FIFO for one ping-pong bank; head is valid whenever the bank is non-empty.
module stamp_bank_fifo #(
   parameter int W     = 14,
   parameter int DEPTH = 16
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/stamp_spike_dispatcher.sv
// Buffers stamped spike events in two ping-pong banks and releases a bank once its time step begins.
//
//   state | meaning
//   IDLE  | waiting for the generator's step pulse
//   WAIT  | one cycle for neuron_stamp to advance, then latch it as cur
//   DRAIN | popping bank cur[0] onto the registered output
//   DONE  | one-cycle step_done pulse
module stamp_spike_dispatcher #(
   parameter int ADDR_W  = 10,
   parameter int DEPTH   = 16,
   parameter int STAMP_W = stamp_pkg::STAMP_W
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               in_valid,
   input  logic [STAMP_W-1:0] in_stamp,
   input  logic [ADDR_W-1:0]  in_addr,
   output logic               in_ready,
   input  logic [STAMP_W-1:0] neuron_stamp,
   input  logic               step_pulse,
   output logic               out_valid,
   output logic [ADDR_W-1:0]  out_addr,
   output logic [STAMP_W-1:0] out_stamp,
   input  logic               out_ready,
   output logic [1:0]         bank_empty,
   output logic               step_done,
   output logic               overrun,
   output logic [7:0]         drop_cnt
);

   import stamp_pkg::*;

   localparam int EW = STAMP_W + ADDR_W;
   localparam int CW = $clog2(DEPTH) + 1;

   disp_state_t        state, state_nxt;
   logic [STAMP_W-1:0] cur;
   logic [STAMP_W-1:0] stamp_nxt;
   logic               in_cur, in_nxt, in_win, tgt;
   logic               sel, load, cur_ld;
   logic [1:0]         push_b, pop_b, full_b, empty_b;
   logic [EW-1:0]      head_b  [2];
   logic [CW-1:0]      count_b [2];

   assign stamp_nxt = neuron_stamp + 1'b1;
   assign sel       = cur[0];
   assign step_done = (state == DONE);

   // The two window stamps differ in bit 0, so each maps to its own bank.
   always_comb begin
      in_cur   = (in_stamp == neuron_stamp);
      in_nxt   = (in_stamp == stamp_nxt);
      in_win   = in_cur || in_nxt;
      tgt      = in_cur ? neuron_stamp[0] : stamp_nxt[0];
      in_ready = !in_win || !full_b[tgt];
      push_b   = 2'b00;
      if (in_valid && in_win && !full_b[tgt]) push_b[tgt] = 1'b1;
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      stamp_bank_fifo #(
         .W     (EW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .CLK       (CLK),
         .RST_N     (RST_N),
         .push      (push_b[b]),
         .push_data ({in_stamp, in_addr}),
         .pop       (pop_b[b]),
         .head      (head_b[b]),
         .full      (full_b[b]),
         .empty     (empty_b[b]),
         .count     (count_b[b])
      );
      assign bank_empty[b] = (count_b[b] == '0);
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      cur_ld    = 1'b0;
      pop_b     = 2'b00;
      case (state)
         IDLE: begin
            if (step_pulse) state_nxt = WAIT;
         end
         WAIT: begin
            cur_ld    = 1'b1;
            state_nxt = DRAIN;
         end
         DRAIN: begin
            if ((!out_valid || out_ready) && !empty_b[sel]) begin
               load       = 1'b1;
               pop_b[sel] = 1'b1;
            end else if (empty_b[sel] && !push_b[sel] && (!out_valid || out_ready)) begin
               // A same-cycle push for cur keeps the step open so it is dispatched now.
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         cur       <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_stamp <= '0;
         overrun   <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (cur_ld) cur <= neuron_stamp;
         if (load) begin
            {out_stamp, out_addr} <= head_b[sel];
            out_valid             <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (step_pulse && (state != IDLE)) overrun <= 1'b1;
         if (in_valid && !in_win && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_stamp_spike_dispatcher.sv
// Scoreboard bench for stamp_spike_dispatcher with a per-stamp reference model.
module tb_stamp_spike_dispatcher;
   import stamp_pkg::*;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 16;
   localparam int SW     = 4;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              in_valid, in_ready, step_pulse;
   logic [SW-1:0]     in_stamp, neuron_stamp, out_stamp;
   logic [ADDR_W-1:0] in_addr, out_addr;
   logic              out_valid, out_ready, step_done, overrun;
   logic [1:0]        bank_empty;
   logic [7:0]        drop_cnt;

   always #5 CLK = ~CLK;

   stamp_spike_dispatcher #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .STAMP_W(SW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .in_valid(in_valid), .in_stamp(in_stamp), .in_addr(in_addr), .in_ready(in_ready),
      .neuron_stamp(neuron_stamp), .step_pulse(step_pulse),
      .out_valid(out_valid), .out_addr(out_addr), .out_stamp(out_stamp), .out_ready(out_ready),
      .bank_empty(bank_empty), .step_done(step_done), .overrun(overrun), .drop_cnt(drop_cnt)
   );

   int         total = 0;
   int         bad = 0;
   spike_evt_t sb[$];
   spike_evt_t pend[$];
   int         exp_drop = 0;
   bit         exp_ovr = 0;
   int         done_cnt = 0;
   int         done_base = 0;
   int         rdy_mode = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int occ(input logic [SW-1:0] st);
      int n = 0;
      foreach (pend[i]) if (pend[i].stamp == st) n++;
      return n;
   endfunction

   function automatic logic [1:0] exp_bank_empty();
      logic [1:0] be = 2'b11;
      foreach (pend[i]) be[pend[i].stamp[0]] = 1'b0;
      return be;
   endfunction

   // Monitor: every handshake must match the head of the expected queue.
   spike_evt_t        e;
   logic              stall_q = 1'b0;
   logic [ADDR_W-1:0] hold_addr;
   logic [SW-1:0]     hold_stamp;
   always @(negedge CLK) begin
      if (!RST_N) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) check("hold", {out_valid, out_stamp, out_addr}, {1'b1, hold_stamp, hold_addr});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_out", {out_stamp, out_addr}, 32'hFFFF_FFFF);
            else begin
               e = sb.pop_front();
               check("out_evt", {out_stamp, out_addr}, {e.stamp, e.addr});
            end
         end
         if (step_done) done_cnt++;
         stall_q    = out_valid && !out_ready;
         hold_addr  = out_addr;
         hold_stamp = out_stamp;
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge CLK); #2;
         if (rdy_mode == 1)      out_ready = ($urandom_range(0, 3) != 0);
         else if (rdy_mode == 2) out_ready = 1'b0;
         else                    out_ready = 1'b1;
      end
   end

   task automatic push_evt(input logic [SW-1:0] st, input logic [ADDR_W-1:0] ad, input bit chk);
      logic [SW-1:0] nx;
      bit            win, rdy;
      spike_evt_t    ev;
      in_valid = 1'b1; in_stamp = st; in_addr = ad;
      #1;
      nx  = neuron_stamp + 4'd1;
      win = (st == neuron_stamp) || (st == nx);
      rdy = !win || (occ(st) < DEPTH);
      if (chk) check("in_ready", in_ready, rdy);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      if (rdy) begin
         if (win) begin
            ev.stamp = st; ev.addr = ad;
            pend.push_back(ev);
         end else if (exp_drop < 255) exp_drop++;
      end
   endtask

   function automatic logic [SW-1:0] oow_stamp();
      return neuron_stamp + 4'(2 + $urandom_range(0, 13));
   endfunction

   task automatic do_step(input bit chk_lat);
      spike_evt_t keep[$];
      done_base  = done_cnt;
      step_pulse = 1'b1;
      @(posedge CLK); #1;
      step_pulse   = 1'b0;
      neuron_stamp = neuron_stamp + 4'd1;
      foreach (pend[i]) begin
         if (pend[i].stamp == neuron_stamp) sb.push_back(pend[i]);
         else keep.push_back(pend[i]);
      end
      pend = keep;
      if (chk_lat && sb.size() > 0) begin
         check("lat_c1", out_valid, 0);
         @(posedge CLK); #1 check("lat_c2", out_valid, 0);
         @(posedge CLK); #1 check("lat_c3", out_valid, 1);
      end
   endtask

   task automatic wait_done(input int budget);
      int i = 0;
      while (done_cnt == done_base && i < budget) begin
         @(posedge CLK); #1; i++;
      end
      repeat (3) @(posedge CLK);
      #1;
      check("step_done_once", done_cnt - done_base, 1);
      check("drained", sb.size(), 0);
   endtask

   task automatic wait_out_valid(input int budget);
      int i = 0;
      while (!out_valid && i < budget) begin
         @(posedge CLK); #1; i++;
      end
      check("out_valid_seen", out_valid, 1);
   endtask

   initial begin
      in_valid = 0; in_stamp = 0; in_addr = 0; step_pulse = 0; neuron_stamp = 4'd3;
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_addr", out_addr, 0);
      check("rst_out_stamp", out_stamp, 0);
      check("rst_step_done", step_done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_bank_empty", bank_empty, 2'b11);
      #5 RST_N = 1'b1;
      @(posedge CLK); #1;

      // Out-of-window drops and saturation
      push_evt(4'd6, 10'd1, 1);
      push_evt(4'd2, 10'd2, 1);
      check("drop_two", drop_cnt, 2);
      check("drop_nothing_buffered", bank_empty, 2'b11);
      for (int i = 0; i < 298; i++) push_evt(oow_stamp(), 10'($urandom), 1);
      check("drop_sat", drop_cnt, 255);
      check("drop_model", drop_cnt, exp_drop);

      // Basic step with latency check
      push_evt(4'd4, 10'd5, 1);
      push_evt(4'd4, 10'd6, 1);
      push_evt(4'd4, 10'd7, 1);
      check("basic_be", bank_empty, 2'b10);
      do_step(1);
      wait_done(60);
      check("basic_empty", bank_empty, 2'b11);

      // Full bank with a stalled 17th event
      for (int i = 0; i < DEPTH; i++) push_evt(4'd5, 10'(100 + i), 1);
      in_valid = 1'b1; in_stamp = 4'd5; in_addr = 10'd999;
      #1;
      check("full_stall", in_ready, 0);
      check("full_be", bank_empty, 2'b01);
      do_step(0);
      begin
         int n = 0;
         while (!in_ready && n < 20) begin
            @(posedge CLK); #1; n++;
         end
         check("stall_accept", in_ready, 1);
         @(posedge CLK); #1;
         in_valid = 1'b0;
         e.stamp = 4'd5; e.addr = 10'd999;
         sb.push_back(e);
      end
      wait_done(80);

      // Backpressure
      for (int i = 0; i < 4; i++) push_evt(4'd6, 10'($urandom), 1);
      do_step(0);
      wait_out_valid(20);
      rdy_mode  = 2;
      out_ready = 1'b0;
      begin
         logic [ADDR_W-1:0] saved;
         saved = out_addr;
         repeat (5) begin
            @(posedge CLK); #1;
            check("bp_valid", out_valid, 1);
            check("bp_addr", out_addr, saved);
         end
         check("bp_no_done", done_cnt - done_base, 0);
      end
      rdy_mode = 1;
      wait_done(100);
      check("bp_be", bank_empty, exp_bank_empty());

      // Random steps with traffic during drain
      for (int s = 0; s < 20; s++) begin
         int n;
         rdy_mode = 1;
         n = $urandom_range(0, 10);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) push_evt(oow_stamp(), 10'($urandom), 1);
            else push_evt(neuron_stamp + 4'd1, 10'($urandom), 1);
         end
         do_step(bit'($urandom_range(0, 1)));
         fork
            wait_done(200);
            begin
               int m = $urandom_range(0, 4);
               for (int j = 0; j < m; j++) begin
                  if ($urandom_range(0, 2) == 0) push_evt(oow_stamp(), 10'($urandom), 1);
                  else push_evt(neuron_stamp + 4'd1, 10'($urandom), 1);
               end
            end
         join
         check("rand_be", bank_empty, exp_bank_empty());
      end
      check("rand_drop", drop_cnt, exp_drop);
      check("rand_ovr", overrun, 0);

      // Flush leftovers, then wrap from 15 to 0 with an overrun pulse
      rdy_mode = 0;
      do_step(0);
      wait_done(200);
      neuron_stamp = 4'd15;
      for (int i = 0; i < 3; i++) push_evt(4'd0, 10'(200 + i), 1);
      check("wrap_be", bank_empty, 2'b10);
      do_step(0);
      wait_out_valid(20);
      step_pulse = 1'b1;
      @(posedge CLK); #1;
      step_pulse = 1'b0;
      exp_ovr    = 1'b1;
      wait_done(100);
      check("wrap_overrun", overrun, exp_ovr);
      check("wrap_empty", bank_empty, 2'b11);

      // Reset in the middle of a drain
      for (int i = 0; i < 4; i++) push_evt(4'd1, 10'(300 + i), 1);
      do_step(0);
      wait_out_valid(20);
      RST_N = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_be", bank_empty, 2'b11);
      check("mid_rst_drop", drop_cnt, 0);
      check("mid_rst_ovr", overrun, 0);
      sb.delete(); pend.delete(); exp_drop = 0; exp_ovr = 0;
      @(posedge CLK); #3;
      RST_N = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      check("post_rst_quiet", out_valid, 0);
      do_step(0);
      wait_done(40);
      check("post_rst_be", bank_empty, 2'b11);
      check("post_rst_ovr", overrun, exp_ovr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stamp_spike_dispatcher.md
Name: stamp_spike_dispatcher

Overview:
- Consumer side of the timestamp protocol: accepts encoded spike events tagged with the 4-bit encode stamp, buffers them per time step, and releases them to the neuron core only once that time step begins.
- Uses two ping-pong banks selected by stamp bit 0.
- Reports per-bank empty status back to the stamp generator. A new step starts on the generator's step pulse (refractory-event pulse).

Parameters:
- ADDR_W, 10, width of the neuron/axon address carried by an event.
- DEPTH, 16, entries per bank (power of 2, >=2).
- STAMP_W, 4, timestamp width; all stamp arithmetic is mod 2^STAMP_W.

Ports:
- CLK  input  1  clock.
- RST_N  input  1  asynchronous active-low reset.
- in_valid  input  1  spike event offered.
- in_stamp  input  STAMP_W  time step the event belongs to.
- in_addr  input  ADDR_W  event address.
- in_ready  output  1  event accepted this cycle when in_valid && in_ready.
- neuron_stamp  input  STAMP_W  current neuron time step from the stamp generator.
- step_pulse  input  1  one-cycle pulse; neuron_stamp increments on the following cycle.
- out_valid  output  1  registered event valid to the core.
- out_addr  output  ADDR_W  registered event address.
- out_stamp  output  STAMP_W  registered event stamp.
- out_ready  input  1  core accepts the event.
- bank_empty  output  2  bank_empty[b]=1 when bank b holds no entries.
- step_done  output  1  one-cycle pulse: the current step is fully dispatched.
- overrun  output  1  sticky flag; cleared only by reset.
- drop_cnt  output  8  saturating count of out-of-window events.

Behaviour:
- Reset (async, RST_N=0):
  - Both banks emptied; state IDLE.
  - Outputs: out_valid=0, out_addr=0, out_stamp=0, step_done=0, overrun=0, drop_cnt=0, bank_empty=2'b11.
  - Reset mid-drain discards all buffered and in-flight events.
- Input window (combinational):
  - in_stamp==neuron_stamp → target bank neuron_stamp[0].
  - in_stamp==neuron_stamp+1 → target bank (neuron_stamp+1)[0]. The two window stamps always map to different banks.
  - Any other stamp → drop.
- in_ready:
  - In-window event: in_ready=1 iff the target bank is not full.
  - Out-of-window event: in_ready=1 always; the event is discarded and drop_cnt increments, saturating at 255.
  - A write to a full bank never occurs.
- Bank FIFO:
  - Show-ahead: head is visible combinationally.
  - Same-cycle push and pop on one bank is legal; count is unchanged.
  - Full when count==DEPTH. Empty when count==0.
  - Pointers wrap mod DEPTH.
- FSM states: IDLE, WAIT, DRAIN, DONE.
  - IDLE: on step_pulse → WAIT.
  - WAIT: one cycle so that neuron_stamp has advanced. Latch cur=neuron_stamp → DRAIN.
  - DRAIN:
    - Load condition: out_valid==0 or out_ready==1, and bank cur[0] is non-empty.
    - On load: pop the head into out_addr/out_stamp and set out_valid=1.
    - Otherwise, out_valid clears on handshake.
    - Events for cur that arrive during DRAIN are dispatched in the same step.
    - Exit to DONE when bank cur[0] is empty and (out_valid==0, or out_ready==1 this cycle with no reload).
  - DONE: step_done=1 for exactly one cycle → IDLE.
- Output holding: while out_valid && !out_ready, out_addr and out_stamp are held stable.
- Latency: first out_valid appears 3 cycles after step_pulse (WAIT, DRAIN load, registered output).
- Overrun: step_pulse in WAIT, DRAIN or DONE sets overrun=1 and is otherwise ignored. The step is not restarted.
- Simultaneous events: an in-window push and a dispatch pop in the same cycle are both honoured. step_pulse in IDLE is never blocked by input traffic.
- Outside DRAIN no pops occur: the next-step bank only accumulates.

Decomposition:
- Shared package stamp_pkg holds:
  - STAMP_W and the state enum type (IDLE/WAIT/DRAIN/DONE).
  - An event struct {stamp, addr}, shared with the encoder side.
- Sub-module stamp_bank_fifo: one parameterised show-ahead FIFO with push/pop/full/empty/count. It is instantiated twice (bank 0, bank 1).

Test Plan:
- Basic step, neuron_stamp=3: push addr 5,6,7 with stamp 4; step_pulse; neuron_stamp→4.
  - out_addr 5,6,7 in order, stamp 4; first out_valid 3 cycles after the pulse.
  - Then step_done pulses once and bank_empty=2'b11.
- Window and drop, neuron_stamp=3: push stamp 6 and stamp 2.
  - Both are taken with in_ready=1; drop_cnt=2; nothing is buffered.
  - Drive 300 such drops → drop_cnt saturates at 255.
- Full bank, DEPTH=16: push 17 events with stamp neuron_stamp+1.
  - in_ready=0 on the 17th.
  - Fire step_pulse; as the first pop occurs, the stalled event is accepted; all 17 are dispatched.
- Backpressure: hold out_ready=0 for 5 cycles during DRAIN.
  - out_valid stays 1 with out_addr stable; no event is lost or duplicated.
  - step_done only after the last handshake.
- Wrap and overrun:
  - neuron_stamp=15 with events at stamp 0 → accepted into bank 0 and dispatched after the stamp wraps to 0.
  - A second step_pulse during DRAIN → overrun=1 and the dispatch completes normally.
- Reset mid-drain: assert RST_N=0 with 4 events queued.
  - Immediately out_valid=0 and bank_empty=2'b11.
  - After release, the state is IDLE and nothing is dispatched.
